// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-safe divisor update controller (req_valid_i/req_div_i/req_ready_o in, rsp_valid_o/rsp_err_o/rsp_ready_i out, div_o to divider, boundary_o period edge, busy_o not idle)
module clk_div_ctrl #(
  parameter int DIV_WIDTH = 4,
  parameter int DEFAULT_DIV = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 req_valid_i,
  input  logic [DIV_WIDTH-1:0] req_div_i,
  output logic                 req_ready_o,
  output logic                 rsp_valid_o,
  output logic                 rsp_err_o,
  input  logic                 rsp_ready_i,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 boundary_o,
  output logic                 busy_o
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, SETTLE, RESP} state_t;
  state_t state, state_d;
  logic [DIV_WIDTH-1:0] cnt, cnt_d, div_d, pend, pend_d;
  logic [SW-1:0] scnt, scnt_d;
  logic err, err_d, acc, load;
  assign boundary_o = cnt == div_o - DIV_WIDTH'(1);
  assign req_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign rsp_valid_o = state == RESP;
  assign rsp_err_o = state == RESP && err;
  always_comb begin
    acc = req_valid_i && state == IDLE;
    load = state == WAIT && boundary_o;
    cnt_d = boundary_o ? '0 : cnt + 1'b1;
    div_d = load ? pend : div_o;
    pend_d = acc ? req_div_i : pend;
    err_d = acc ? req_div_i == '0 : err;
    scnt_d = load ? SW'(SETTLE_CYCLES - 1) : (state == SETTLE && scnt != '0) ? scnt - 1'b1 : scnt;
    state_d = state;
    case (state)
      IDLE:    state_d = !acc ? IDLE : (req_div_i == '0 || req_div_i == div_o) ? RESP : WAIT;
      WAIT:    state_d = boundary_o ? SETTLE : WAIT;
      SETTLE:  state_d = scnt == '0 ? RESP : SETTLE;
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state <= IDLE;
      cnt <= '0;
      div_o <= DIV_WIDTH'(DEFAULT_DIV);
      pend <= DIV_WIDTH'(DEFAULT_DIV);
      scnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      div_o <= div_d;
      pend <= pend_d;
      scnt <= scnt_d;
      err <= err_d;
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;
  logic clk_i = 1'b0;
  logic arst_ni, req_valid_i, rsp_ready_i;
  logic [3:0] req_div_i;
  logic req_ready_o, rsp_valid_o, rsp_err_o, boundary_o, busy_o;
  logic [3:0] div_o;
  int checks = 0;
  int errors = 0;
  clk_div_ctrl #(.DIV_WIDTH(4), .DEFAULT_DIV(2), .SETTLE_CYCLES(2)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .req_valid_i(req_valid_i), .req_div_i(req_div_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
    .rsp_ready_i(rsp_ready_i), .div_o(div_o), .boundary_o(boundary_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask
  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid_o && n < 40) begin
      tick();
      n++;
    end
    check(tag, rsp_valid_o, 1);
  endtask
  task automatic handshake();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask
  initial begin
    arst_ni = 1'b1;
    req_valid_i = 1'b0;
    req_div_i = '0;
    rsp_ready_i = 1'b0;
    #1 arst_ni = 1'b0;
    @(negedge clk_i);
    check("rst_div", div_o, 2);
    check("rst_ready", req_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_bnd", boundary_o, 0);
    tick();
    check("rst_hold_div", div_o, 2);
    arst_ni = 1'b1;
    check("rel_bnd0", boundary_o, 0);
    tick();
    check("rel_bnd1", boundary_o, 1);
    tick();
    check("rel_bnd2", boundary_o, 0);
    // reject divisor 0
    req_valid_i = 1'b1;
    req_div_i = 4'd0;
    tick();
    req_valid_i = 1'b0;
    check("zero_valid", rsp_valid_o, 1);
    check("zero_err", rsp_err_o, 1);
    check("zero_div", div_o, 2);
    check("zero_cnt_bnd", boundary_o, 1);
    check("zero_busy", busy_o, 1);
    check("zero_ready", req_ready_o, 0);
    handshake();
    check("zero_done_valid", rsp_valid_o, 0);
    check("zero_done_ready", req_ready_o, 1);
    check("zero_done_bnd", boundary_o, 0);
    // no-change request
    req_valid_i = 1'b1;
    req_div_i = 4'd2;
    tick();
    req_valid_i = 1'b0;
    check("same_valid", rsp_valid_o, 1);
    check("same_err", rsp_err_o, 0);
    check("same_div", div_o, 2);
    handshake();
    // change to 5 accepted while count=0
    check("chg_ready", req_ready_o, 1);
    check("chg_cnt0", boundary_o, 0);
    req_valid_i = 1'b1;
    req_div_i = 4'd5;
    tick();
    req_valid_i = 1'b0;
    check("chg_wait_busy", busy_o, 1);
    check("chg_wait_div", div_o, 2);
    check("chg_wait_bnd", boundary_o, 1);
    tick();
    check("chg_div5", div_o, 5);
    check("chg_settle_valid0", rsp_valid_o, 0);
    tick();
    check("chg_settle_valid1", rsp_valid_o, 0);
    tick();
    check("chg_rsp_valid", rsp_valid_o, 1);
    check("chg_rsp_err", rsp_err_o, 0);
    tick();
    check("chg_rsp_hold", rsp_valid_o, 1);
    handshake();
    check("chg_idle", req_ready_o, 1);
    check("chg_bnd_c4", boundary_o, 1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("per5_%0d", i), boundary_o, (i % 5 == 0) ? 1 : 0);
    end
    // held response with pending request 7
    req_valid_i = 1'b1;
    req_div_i = 4'd5;
    tick();
    req_div_i = 4'd7;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold_valid_%0d", i), rsp_valid_o, 1);
      check($sformatf("hold_ready_%0d", i), req_ready_o, 0);
      tick();
    end
    check("hold_err", rsp_err_o, 0);
    check("hold_div", div_o, 5);
    handshake();
    check("hs_ready", req_ready_o, 1);
    check("hs_valid", rsp_valid_o, 0);
    check("hs_div", div_o, 5);
    tick();
    req_valid_i = 1'b0;
    check("acc7_busy", busy_o, 1);
    check("acc7_valid", rsp_valid_o, 0);
    wait_rsp("acc7_rsp");
    check("acc7_div", div_o, 7);
    check("acc7_err", rsp_err_o, 0);
    handshake();
    // move to 15, then reset mid-WAIT with request 9
    req_valid_i = 1'b1;
    req_div_i = 4'd15;
    tick();
    req_valid_i = 1'b0;
    wait_rsp("to15_rsp");
    check("to15_div", div_o, 15);
    handshake();
    begin
      int n;
      n = 0;
      while (!boundary_o && n < 40) begin
        tick();
        n++;
      end
      check("to15_bnd_seen", boundary_o, 1);
    end
    tick();
    tick();
    tick();
    tick();
    req_valid_i = 1'b1;
    req_div_i = 4'd9;
    tick();
    req_valid_i = 1'b0;
    tick();
    check("r9_busy", busy_o, 1);
    check("r9_div", div_o, 15);
    #2 arst_ni = 1'b0;
    #1;
    check("arst_div", div_o, 2);
    check("arst_busy", busy_o, 0);
    check("arst_ready", req_ready_o, 1);
    check("arst_valid", rsp_valid_o, 0);
    check("arst_bnd", boundary_o, 0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    tick();
    check("post_bnd1", boundary_o, 1);
    check("post_valid", rsp_valid_o, 0);
    tick();
    check("post_bnd0", boundary_o, 0);
    check("post_div", div_o, 2);
    req_valid_i = 1'b1;
    req_div_i = 4'd3;
    tick();
    req_valid_i = 1'b0;
    check("post_busy", busy_o, 1);
    wait_rsp("post_rsp");
    check("post_err", rsp_err_o, 0);
    check("post_div3", div_o, 3);
    handshake();
    check("post_idle", req_ready_o, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DIV_WIDTH, 4, width of divisor values.
- DEFAULT_DIV, 2, divisor driven after reset; SHALL be nonzero.
- SETTLE_CYCLES, 2, clk_i cycles to wait after a divisor change before responding; SHALL be at least 1.

REQ-002 The block SHALL have one clock, clk_i, and an asynchronous, active-low reset, arst_ni.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- arst_ni, in, 1, asynchronous active-low reset.
- req_valid_i, in, 1, divisor change request valid.
- req_div_i, in, DIV_WIDTH, requested divisor.
- req_ready_o, out, 1, controller can accept a request.
- rsp_valid_o, out, 1, response valid.
- rsp_err_o, out, 1, request rejected; meaningful only while rsp_valid_o=1.
- rsp_ready_i, in, 1, response consumed.
- div_o, out, DIV_WIDTH, divisor driven to the clock divider's div_i.
- boundary_o, out, 1, output-period boundary: shadow count equals div_o-1.
- busy_o, out, 1, controller is not in IDLE.

Function
REQ-004 The block SHALL hold a DIV_WIDTH-bit shadow counter that tracks the divider's counter exactly:
- 0 after reset.
- On each clk_i rising edge, wraps to 0 when equal to div_o-1 (modulo 2^DIV_WIDTH), otherwise increments by 1.

REQ-005 boundary_o SHALL be combinational and equal 1 exactly when the shadow count equals div_o-1.

REQ-006 The FSM SHALL have four states: IDLE, WAIT, SETTLE, RESP.

REQ-007 req_ready_o SHALL be 1 only in IDLE, and busy_o SHALL be 1 in every state except IDLE.

REQ-008 A request SHALL be accepted on a rising edge where req_valid_i=1 and req_ready_o=1; req_div_i SHALL then be latched into a pending register.

REQ-009 In IDLE, on acceptance, the next state SHALL be:
- RESP with error=1 if req_div_i=0;
- RESP with error=0 if req_div_i=div_o;
- WAIT otherwise.

REQ-010 In WAIT, on the first rising edge where boundary_o=1, the block SHALL:
- load div_o from the pending register;
- wrap the shadow count to 0 on the same edge;
- enter SETTLE with the settle counter loaded to SETTLE_CYCLES-1.

REQ-011 div_o SHALL change only on an edge defined in REQ-010, so the divider never sees a mid-period divisor change.

REQ-012 In SETTLE, the settle counter SHALL decrement each cycle; on the edge where it equals 0, the block SHALL enter RESP with error=0.
- SETTLE therefore lasts exactly SETTLE_CYCLES cycles.

REQ-013 In RESP:
- rsp_valid_o SHALL be 1 and rsp_err_o SHALL show the latched error.
- Both SHALL stay stable until a rising edge with rsp_ready_i=1, after which the state SHALL return to IDLE.
- rsp_ready_i SHALL be ignored outside RESP.

REQ-014 A request presented while req_ready_o=0 SHALL NOT be accepted and SHALL have no effect.
- A request SHALL be acceptable on the edge immediately after the RESP handshake.

REQ-015 Worst-case latency from acceptance to rsp_valid_o SHALL be div_o(old)+SETTLE_CYCLES cycles. The minimum SHALL be:
- SETTLE_CYCLES+1 for an accepted change;
- 1 for a rejected or no-change request.

REQ-016 A divisor of 1 SHALL be legal; boundary_o is then constantly 1.

Reset
REQ-017 While arst_ni=0, asynchronously:
- state=IDLE;
- div_o=DEFAULT_DIV;
- shadow count=0;
- settle counter=0;
- pending register=DEFAULT_DIV;
- error=0;
- req_ready_o=1;
- rsp_valid_o=0, rsp_err_o=0;
- busy_o=0.

REQ-018 A reset asserted in any state, including mid-WAIT or mid-SETTLE, SHALL abandon the transaction with no response and restore the values in REQ-017.

REQ-019 On reset release, the shadow count SHALL restart in lockstep with the divider counter, which shares clk_i and arst_ni.

Verification
REQ-020 The bench SHALL cover these directed scenarios (DIV_WIDTH=4, DEFAULT_DIV=2, SETTLE_CYCLES=2):
- Reset then release -> div_o=2, req_ready_o=1, rsp_valid_o=0, boundary_o=1 on the 2nd cycle after release (count 0,1,0,1...).
- Request 5 accepted while count=0 -> WAIT one cycle, div_o=5 at the next edge, rsp_valid_o=1 with rsp_err_o=0 two cycles later; boundary_o then pulses every 5 cycles.
- Request 0 -> rsp_valid_o=1 and rsp_err_o=1 on the cycle after acceptance; div_o stays 2 and count is unaffected.
- Request 2 while div_o=2 -> rsp_valid_o=1 and rsp_err_o=0 after 1 cycle; div_o is unchanged.
- rsp_ready_i held 0 for 10 cycles while req_valid_i=1 with value 7 -> rsp_valid_o is held, req_ready_o=0, 7 is not accepted until after the handshake.
- Request 9 from div_o=15 and count=3, then arst_ni pulsed low during WAIT -> div_o=2 immediately, no response, and the next request is accepted normally.
